// File: rtl/load_store_unit.sv
// Load/store unit: accepts one decoded memory op, runs a single bus transaction
// with lane steering, byte-enable generation, load extension and a bus timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  access_sz,
    input  logic        s_us,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_in,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_we,
    output logic [1:0]  resp_err
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state, state_nx;
    logic [29:0] addr_q;
    logic [1:0]  lane_q, sz_q, err_q;
    logic        sus_q, load_q;
    logic [4:0]  rd_q;
    logic [3:0]  be_q, be_new;
    logic [31:0] wdata_q, wdata_new, rdata_q, shifted, load_ext;
    logic [15:0] cnt;
    logic        accept, misaligned, timeout;

    always_comb begin
        be_new     = '0;
        wdata_new  = '0;
        misaligned = 1'b0;
        case (access_sz)
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new     = 4'b0011 << addr[1:0];
                wdata_new  = {2{wdata[15:0]}};
                misaligned = addr[0];
            end
            2'b10: begin
                be_new     = 4'b1111;
                wdata_new  = wdata;
                misaligned = |addr[1:0];
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Timeout fires on the BUS cycle whose missing ack would bring the count to TIMEOUT
    always_comb begin
        accept   = req_valid && (state == IDLE) && (mem_read ^ mem_write);
        timeout  = ({1'b0, cnt} + 17'd1) == 17'(TIMEOUT);
        shifted  = bus_rdata >> {lane_q, 3'b000};
        load_ext = '0;
        case (sz_q)
            2'b00:   load_ext = sus_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = sus_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = misaligned ? RESP : BUS;
            BUS:     if (bus_ack || timeout) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            lane_q  <= '0;
            sz_q    <= '0;
            sus_q   <= 1'b0;
            load_q  <= 1'b0;
            rd_q    <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= '0;
            cnt     <= '0;
        end else if (accept) begin
            addr_q  <= addr[31:2];
            lane_q  <= addr[1:0];
            sz_q    <= access_sz;
            sus_q   <= s_us;
            load_q  <= mem_read;
            rd_q    <= rd_in;
            be_q    <= be_new;
            wdata_q <= wdata_new;
            rdata_q <= '0;
            err_q   <= misaligned ? 2'b01 : 2'b00;
            cnt     <= '0;
        end else if (state == BUS) begin
            if (bus_ack) begin
                if (load_q) rdata_q <= load_ext;
            end else begin
                cnt <= cnt + 16'd1;
                if (timeout) err_q <= 2'b10;
            end
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        bus_req    = (state == BUS);
        bus_we     = bus_req && !load_q;
        bus_addr   = bus_req ? {addr_q, 2'b00} : '0;
        bus_be     = bus_req ? be_q : '0;
        bus_wdata  = bus_req ? wdata_q : '0;
        resp_valid = (state == RESP);
        resp_rdata = resp_valid ? rdata_q : '0;
        resp_rd    = resp_valid ? rd_q : '0;
        resp_err   = resp_valid ? err_q : '0;
        resp_we    = resp_valid && load_q && (err_q == 2'b00);
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed literal cases plus random ops
// compared every cycle against a transaction-level timeline model.
module tb_load_store_unit;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, mem_read, mem_write, s_us;
    logic [1:0]  access_sz;
    logic [31:0] addr, wdata;
    logic [4:0]  rd_in;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        resp_valid, resp_we;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_err;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .access_sz(access_sz), .s_us(s_us),
        .addr(addr), .wdata(wdata), .rd_in(rd_in), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_we(resp_we), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected transaction: timeline positions and values
    bit          active = 0;
    int          t, t_end, n_bus;
    bit          e_mis, e_wr, e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    logic [1:0]  e_err;
    logic [4:0]  e_rd;

    // Captured DUT values for the literal checks
    int          bus_cycles, resp_t;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;
    logic [1:0]  r_err;
    logic        r_we, r_bwe;

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sus,
                                               input logic [31:0] a, input logic [31:0] d);
        longint v;
        v = longint'(d) / (longint'(1) << (8 * (a % 4)));
        if (sz == 2'd0) begin
            v = v % 256;
            if (!sus && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = v % 65536;
            if (!sus && v >= 32768) v = v - 65536;
        end
        return 32'(v);
    endfunction

    task automatic run_op(input bit rd, input bit wr, input logic [1:0] sz, input bit sus,
                          input logic [31:0] a, input logic [31:0] w, input logic [4:0] rdn,
                          input int ack_at, input logic [31:0] rdata);
        bit ign, acked;
        logic [3:0] be;
        ign   = (rd == wr);
        e_mis = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
        acked = (ack_at >= 1 && ack_at <= int'(TO));
        n_bus = acked ? ack_at : int'(TO);
        t_end = ign ? 0 : (e_mis ? 1 : n_bus + 1);
        e_wr  = wr;
        e_rd  = rdn;
        e_addr = a & 32'hFFFF_FFFC;
        be = (sz == 2'd0) ? 4'b0001 : 4'b0011;
        e_be = (sz == 2'd2) ? 4'hF : 4'(be * (1 << (a % 4)));
        e_wdata = (sz == 2'd0) ? (w % 256) * 32'h0101_0101 :
                  (sz == 2'd1) ? (w % 65536) * 32'h0001_0001 : w;
        e_err   = e_mis ? 2'b01 : (acked ? 2'b00 : 2'b10);
        e_we    = rd && e_err == 2'b00;
        e_rdata = e_we ? model_load(sz, sus, a, rdata) : 32'h0;
        bus_cycles = 0; resp_t = 0;
        r_addr = '0; r_wdata = '0; r_rdata = '0; r_be = '0; r_err = '0; r_we = 0; r_bwe = 0;

        t = 0;
        active = 1;
        req_valid = 1; mem_read = rd; mem_write = wr; access_sz = sz; s_us = sus;
        addr = a; wdata = w; rd_in = rdn;
        bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
        for (int k = 1; k <= t_end; k++) begin
            @(posedge clk); #1;
            t = k;
            req_valid = 1'($urandom_range(0, 1));
            mem_read = 1'($urandom_range(0, 1)); mem_write = ~mem_read;
            access_sz = 2'($urandom_range(0, 3)); s_us = 1'($urandom_range(0, 1));
            addr = $urandom; wdata = $urandom; rd_in = 5'($urandom);
            if (!e_mis && k <= n_bus) begin
                bus_ack   = (k == ack_at);
                bus_rdata = (k == ack_at) ? rdata : $urandom;
            end else begin
                bus_ack   = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end
        end
        @(posedge clk); #1;
        req_valid = 0; bus_ack = 0;
    endtask

    always @(negedge clk) begin
        if (active && rst_n) begin
            if (t == 0) begin
                chk("idle_ready", 32'(req_ready), 32'd1);
                chk("idle_bus_req", 32'(bus_req), 32'd0);
                chk("idle_resp_valid", 32'(resp_valid), 32'd0);
            end else if (!e_mis && t <= n_bus) begin
                chk("bus_req", 32'(bus_req), 32'd1);
                chk("bus_ready", 32'(req_ready), 32'd0);
                chk("bus_resp_valid", 32'(resp_valid), 32'd0);
                chk("bus_we", 32'(bus_we), 32'(e_wr));
                chk("bus_addr", bus_addr, e_addr);
                chk("bus_be", 32'(bus_be), 32'(e_be));
                if (e_wr) chk("bus_wdata", bus_wdata, e_wdata);
                bus_cycles++;
                r_addr = bus_addr; r_be = bus_be; r_wdata = bus_wdata; r_bwe = bus_we;
            end else if (t == t_end) begin
                chk("resp_valid", 32'(resp_valid), 32'd1);
                chk("resp_bus_req", 32'(bus_req), 32'd0);
                chk("resp_ready", 32'(req_ready), 32'd0);
                chk("resp_err", 32'(resp_err), 32'(e_err));
                chk("resp_we", 32'(resp_we), 32'(e_we));
                chk("resp_rdata", resp_rdata, e_rdata);
                if (e_we) chk("resp_rd", 32'(resp_rd), 32'(e_rd));
                resp_t = t;
                r_rdata = resp_rdata; r_err = resp_err; r_we = resp_we;
            end
        end
    end

    initial begin
        rst_n = 0; req_valid = 0; mem_read = 0; mem_write = 0; access_sz = 0; s_us = 0;
        addr = 0; wdata = 0; rd_in = 0; bus_ack = 0; bus_rdata = 0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_rd", 32'(resp_rd), 32'd0);
        chk("rst_resp_we", 32'(resp_we), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // LB 0x103, ack on first BUS cycle
        run_op(1, 0, 2'd0, 0, 32'h103, 32'h0, 5'd7, 1, 32'h80FF_FFFF);
        chk("lb_addr", r_addr, 32'h100);
        chk("lb_be", 32'(r_be), 32'h8);
        chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
        chk("lb_we", 32'(r_we), 32'd1);
        chk("lb_latency", 32'(resp_t), 32'd2);
        // LHU 0x202
        run_op(1, 0, 2'd1, 1, 32'h202, 32'h0, 5'd9, 3, 32'hBEEF_1234);
        chk("lhu_be", 32'(r_be), 32'hC);
        chk("lhu_rdata", r_rdata, 32'h0000_BEEF);
        chk("lhu_latency", 32'(resp_t), 32'd4);
        // SB 0x301
        run_op(0, 1, 2'd0, 0, 32'h301, 32'hA5, 5'd3, 2, 32'h0);
        chk("sb_we", 32'(r_bwe), 32'd1);
        chk("sb_be", 32'(r_be), 32'h2);
        chk("sb_wdata", r_wdata, 32'hA5A5_A5A5);
        chk("sb_resp_we", 32'(r_we), 32'd0);
        chk("sb_err", 32'(r_err), 32'd0);
        // LW 0x402 misaligned
        run_op(1, 0, 2'd2, 0, 32'h402, 32'h0, 5'd4, 1, 32'h0);
        chk("lw_mis_bus", 32'(bus_cycles), 32'd0);
        chk("lw_mis_latency", 32'(resp_t), 32'd1);
        chk("lw_mis_err", 32'(r_err), 32'd1);
        // SW timeout, then ack on the last allowed cycle
        run_op(0, 1, 2'd2, 0, 32'h600, 32'h1234_5678, 5'd0, 0, 32'h0);
        chk("sw_to_cycles", 32'(bus_cycles), 32'd4);
        chk("sw_to_err", 32'(r_err), 32'd2);
        run_op(0, 1, 2'd2, 0, 32'h600, 32'h1234_5678, 5'd0, 4, 32'h0);
        chk("sw_ack4_cycles", 32'(bus_cycles), 32'd4);
        chk("sw_ack4_err", 32'(r_err), 32'd0);
        // Ignored op with both read and write set
        run_op(1, 1, 2'd2, 0, 32'h700, 32'h0, 5'd1, 1, 32'h0);

        for (int n = 0; n < 200; n++) begin
            int kind;
            bit rd, wr;
            logic [1:0] sz;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            rd = (kind == 0) || (kind >= 2 && kind <= 5);
            wr = (kind == 0) || (kind >= 6);
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = (sz == 2'd1) ? (a & ~32'h1) : (a & ~32'h3);
            run_op(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom, 5'($urandom),
                   $urandom_range(1, TO + 2), $urandom);
        end

        // Reset during BUS aborts the transaction
        active = 0;
        req_valid = 1; mem_read = 0; mem_write = 1; access_sz = 2'd2; addr = 32'h500;
        wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 0; bus_ack = 0;
        chk("abort_bus_req_pre", 32'(bus_req), 32'd1);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("abort_bus_req", 32'(bus_req), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
            chk("abort_no_bus", 32'(bus_req), 32'd0);
        end
        @(posedge clk); #1;
        run_op(1, 0, 2'd2, 0, 32'h800, 32'h0, 5'd31, 2, 32'h1357_9BDF);
        chk("post_abort_rdata", r_rdata, 32'h1357_9BDF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum bus wait cycles before abort; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  decoded memory op presented.
REQ-005 req_ready  output  1  unit can accept an op.
REQ-006 mem_read  input  1  op is a load.
REQ-007 mem_write  input  1  op is a store.
REQ-008 access_sz  input  2  size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 s_us  input  1  load extension: 0 signed, 1 unsigned.
REQ-010 addr  input  32  effective byte address (rs1+imm).
REQ-011 wdata  input  32  store data, LSB-aligned.
REQ-012 rd_in  input  5  load destination register.
REQ-013 bus_req  output  1  bus transaction active.
REQ-014 bus_we  output  1  1 write, 0 read.
REQ-015 bus_addr  output  32  word-aligned address, bits [1:0] = 00.
REQ-016 bus_be  output  4  byte-lane enables.
REQ-017 bus_wdata  output  32  lane-shifted store data.
REQ-018 bus_ack  input  1  bus completes transaction this cycle.
REQ-019 bus_rdata  input  32  read word, valid when bus_ack=1.
REQ-020 resp_valid  output  1  one-cycle completion pulse.
REQ-021 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-022 resp_rd  output  5  destination for resp_rdata.
REQ-023 resp_we  output  1  write resp_rdata to register file (successful loads only).
REQ-024 resp_err  output  2  00 ok, 01 misaligned/illegal size, 10 bus timeout.

Function
REQ-025 States: IDLE, BUS, RESP; req_ready=1 only in IDLE.
REQ-026 Accept when req_valid & req_ready & (mem_read ^ mem_write); if both or neither is set, the op is ignored and the unit stays in IDLE.
REQ-027 On accept, latch addr, size, s_us, rd_in and lane-shifted wdata; later input changes have no effect.
REQ-028 Misaligned: half with addr[0]=1, word with addr[1:0]!=00, or size 11 -> IDLE to RESP, no bus_req, resp_err=01.
REQ-029 Aligned accept -> BUS; bus_req=1 from the next cycle until the cycle bus_ack=1, inclusive.
REQ-030 bus_be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-031 bus_wdata: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
REQ-032 bus_addr, bus_we, bus_be and bus_wdata are stable throughout BUS.
REQ-033 On bus_ack in BUS, register the selected lane(s) of bus_rdata, sign- or zero-extended per s_us, then go to RESP.
REQ-034 A 16-bit wait counter clears on entry to BUS and increments each BUS cycle without ack; at count==TIMEOUT without ack, drop bus_req, go to RESP, resp_err=10.
REQ-035 An ack in the same cycle the count reaches TIMEOUT completes normally.
REQ-036 RESP lasts exactly one cycle: resp_valid=1, resp_we=1 only for a load with resp_err=00; next state IDLE.
REQ-037 Accept-to-resp_valid latency = ack-wait cycles + 2 (minimum 2 with ack in the first BUS cycle); misaligned latency = 1.
REQ-038 Back-to-back: a request may be accepted in the cycle after RESP.
REQ-039 bus_ack outside BUS is ignored.

Reset
REQ-040 rst_n low forces state IDLE, counter 0, and all outputs 0 except req_ready=1, independent of clk.
REQ-041 Reset asserted mid-BUS aborts: bus_req drops immediately, no resp_valid is produced.

Verification
REQ-042 LB addr=0x103, bus_rdata=0x80FF_FF_FF (byte3=0x80), ack after 1 cycle -> bus_addr=0x100, bus_be=1000, resp_rdata=0xFFFFFF80, resp_we=1.
REQ-043 LHU addr=0x202, bus_rdata=0xBEEF1234 -> bus_be=1100, resp_rdata=0x0000BEEF.
REQ-044 SB addr=0x301, wdata=0x000000A5 -> bus_we=1, bus_be=0010, bus_wdata=0xA5A5A5A5, resp_valid with resp_we=0, resp_err=00.
REQ-045 LW addr=0x402 -> no bus_req, resp_valid one cycle after accept, resp_err=01.
REQ-046 TIMEOUT=4, SW with no ack -> bus_req high 4 cycles, then resp_err=10; repeat with ack on the 4th cycle -> resp_err=00.
REQ-047 rst_n low during BUS -> bus_req=0 asynchronously, req_ready=1, no resp_valid after release.
